// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM with a memory ready handshake and access-size tracking.
// Define CTRL_EXC_EN to build the EXC state, the memory wait-timeout counter and the exception outputs.
module multicycle_control #(
    parameter int OPCODE_W     = 6,
    parameter int MEM_WAIT_MAX = 15,
    parameter int TMO_W        = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic [1:0]          mem_size,
    output logic                ir_write,
    output logic                reg_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                instr_done,
    output logic                exc_valid,
    output logic [1:0]          exc_cause
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        REX, ALUWB, BRANCH, JUMP, IEX, EXC
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] size_reg, size_next;
    logic       from_rex_reg;
    logic       op_rtype, op_jump, op_beq, op_addi, op_mem;

    if (MEM_WAIT_MAX < 1 || MEM_WAIT_MAX > 255 || (2 ** TMO_W) <= MEM_WAIT_MAX) begin : g_bad_params
        $error("multicycle_control: MEM_WAIT_MAX must be 1..255 and below 2**TMO_W");
    end

    always_comb begin
        op_rtype = (opcode == OPCODE_W'(6'b000000));
        op_jump  = (opcode == OPCODE_W'(6'b000010));
        op_beq   = (opcode == OPCODE_W'(6'b000100));
        op_addi  = (opcode == OPCODE_W'(6'b001000));
        // loads 1000xx and stores 1010xx; the xx=10 encodings have no defined size
        op_mem   = ((opcode[OPCODE_W-1 -: 4] == 4'b1000) || (opcode[OPCODE_W-1 -: 4] == 4'b1010))
                   && (opcode[1:0] != 2'b10);
        case (opcode[1:0])
            2'b01:   size_next = 2'b11;
            2'b00:   size_next = 2'b01;
            default: size_next = 2'b00;
        endcase
    end

`ifdef CTRL_EXC_EN
    logic [TMO_W-1:0] tmo_reg;
    logic [1:0]       cause_reg;
    logic             in_mem_state;
    logic             timeout;

    assign in_mem_state = (state_reg == FETCH) || (state_reg == MEMRD) || (state_reg == MEMWR);
    // Fires in the cycle the count would reach MEM_WAIT_MAX; a ready in that same cycle still wins.
    assign timeout      = in_mem_state && !mem_ready && (tmo_reg == TMO_W'(MEM_WAIT_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_reg   <= '0;
            cause_reg <= 2'b00;
        end else begin
            if (!in_mem_state || mem_ready) begin
                tmo_reg <= '0;
            end else if (tmo_reg != TMO_W'(MEM_WAIT_MAX)) begin
                tmo_reg <= tmo_reg + TMO_W'(1);
            end
            if (state_next == EXC) begin
                cause_reg <= (state_reg == DECODE) ? 2'b01 : 2'b10;
            end
        end
    end

    assign exc_valid = (state_reg == EXC);
    assign exc_cause = cause_reg;
`else
    assign exc_valid = 1'b0;
    assign exc_cause = 2'b00;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= FETCH;
            size_reg     <= 2'b00;
            from_rex_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            from_rex_reg <= (state_reg == REX);
            if (state_reg == DECODE) begin
                size_reg <= size_next;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_size      = size_reg;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        instr_done    = 1'b0;
        case (state_reg)
            FETCH: begin
                mem_read  = 1'b1;
                mem_size  = 2'b00;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_next = DECODE;
                end
`ifdef CTRL_EXC_EN
                else if (timeout) begin
                    state_next = EXC;
                end
`endif
            end
            DECODE: begin
                alu_src_b = 2'b11;
                if (op_rtype) begin
                    state_next = REX;
                end else if (op_jump) begin
                    state_next = JUMP;
                end else if (op_beq) begin
                    state_next = BRANCH;
                end else if (op_addi) begin
                    state_next = IEX;
                end else if (op_mem) begin
                    state_next = MEMADR;
                end else begin
`ifdef CTRL_EXC_EN
                    state_next = EXC;
`else
                    instr_done = 1'b1;
                    state_next = FETCH;
`endif
                end
            end
            MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (opcode[OPCODE_W-1 -: 3] == 3'b101) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready) begin
                    state_next = MEMWB;
                end
`ifdef CTRL_EXC_EN
                else if (timeout) begin
                    state_next = EXC;
                end
`endif
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) begin
                    state_next = FETCH;
                end
`ifdef CTRL_EXC_EN
                else if (timeout) begin
                    state_next = EXC;
                end
`endif
            end
            REX: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                state_next = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = from_rex_reg;
                instr_done = 1'b1;
                state_next = FETCH;
            end
            IEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = ALUWB;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
                state_next    = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                state_next = FETCH;
            end
`ifdef CTRL_EXC_EN
            EXC: begin
                pc_write   = 1'b1;
                pc_source  = 2'b11;
                instr_done = 1'b1;
                state_next = FETCH;
            end
`endif
            default: state_next = FETCH;
        endcase
    end
endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: instruction table with a completion scoreboard plus
// hand-written reset, REX and memory-timeout sequences (MEM_WAIT_MAX overridden to 4).
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a, instr_done, exc_valid;
    logic [1:0] mem_size, alu_src_b, alu_op, pc_source, exc_cause;

    int n_vec  = 0;
    int n_miss = 0;
    int last_aluop3;

`ifdef CTRL_EXC_EN
    localparam int ILL_CYC = 3;
    localparam int ILL_EXC = 3;
`else
    localparam int ILL_CYC = 2;
    localparam int ILL_EXC = 0;
`endif

    typedef struct {
        string      name;
        logic [5:0] op;
        int         fw;       // low mem_ready cycles in FETCH
        int         dw;       // low mem_ready cycles in MEMRD/MEMWR
        int         cyc;      // cycle of instr_done, counting FETCH as 1
        bit         regw;
        bit         dst;
        bit         m2r;
        bit         chk_size;
        logic [1:0] size;
        int         mw;       // cycles with mem_write high
        int         pcc;      // cycle of pc_write_cond, 0 = never
        int         exc;      // cycle of exc_valid, 0 = never
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];

    multicycle_control #(.OPCODE_W(6), .MEM_WAIT_MAX(4), .TMO_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .instr_done(instr_done),
        .exc_valid(exc_valid), .exc_cause(exc_cause)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string n, input logic [5:0] op, input int fw, input int dw,
                                input int cyc, input bit regw, input bit dst, input bit m2r,
                                input bit chk_size, input logic [1:0] size, input int mw,
                                input int pcc, input int exc);
        vec_t v;
        v.name = n; v.op = op; v.fw = fw; v.dw = dw; v.cyc = cyc; v.regw = regw;
        v.dst = dst; v.m2r = m2r; v.chk_size = chk_size; v.size = size; v.mw = mw;
        v.pcc = pcc; v.exc = exc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Entered and left #1 after a rising edge with the DUT in FETCH.
    task automatic run_instr(input vec_t v);
        int         cyc = 0;
        int         fw_cnt = 0;
        int         dw_cnt = 0;
        bit         done = 0;
        bit         o_regw = 0, o_dst = 0, o_m2r = 0;
        logic [1:0] o_size = 2'bxx;
        logic [1:0] o_cause = 2'b00;
        int         o_mw = 0, o_pcc = 0, o_exc = 0;
        vec_t       e;
        sb_q.push_back(v);
        opcode = v.op;
        while (!done && cyc < 40) begin
            cyc++;
            if (mem_read && !iord) begin
                mem_ready = (fw_cnt >= v.fw);
                fw_cnt++;
            end else if (iord && (mem_read || mem_write)) begin
                mem_ready = (dw_cnt >= v.dw);
                dw_cnt++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (cyc == 1)
                check({v.name, "_fetch"}, 32'({mem_read, iord, alu_src_b, mem_size, alu_src_a}), 32'b1001000);
            if (cyc == 3) last_aluop3 = int'(alu_op);
            if (reg_write) begin o_regw = 1; o_dst = reg_dst; o_m2r = mem_to_reg; end
            if (iord && (mem_read || mem_write)) o_size = mem_size;
            if (mem_write) o_mw++;
            if (pc_write_cond && o_pcc == 0) o_pcc = cyc;
            if (exc_valid && o_exc == 0) begin o_exc = cyc; o_cause = exc_cause; end
            if (instr_done) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_vec++;
            n_miss++;
            $display("FAIL %s_done: no instr_done within %0d cycles, expected at cycle %0d", v.name, cyc, v.cyc);
            e = sb_q.pop_front();
            return;
        end
        e = sb_q.pop_front();
        $display("instr %-6s op=%b cycles=%0d reg_write=%0d mem_writes=%0d exc_at=%0d",
                 e.name, e.op, cyc, o_regw, o_mw, o_exc);
        check({e.name, "_cycles"}, 32'(cyc), 32'(e.cyc));
        check({e.name, "_regw"}, 32'(o_regw), 32'(e.regw));
        if (e.regw) begin
            check({e.name, "_regdst"}, 32'(o_dst), 32'(e.dst));
            check({e.name, "_memtoreg"}, 32'(o_m2r), 32'(e.m2r));
        end
        if (e.chk_size) check({e.name, "_size"}, 32'(o_size), 32'(e.size));
        check({e.name, "_memwrite"}, 32'(o_mw), 32'(e.mw));
        check({e.name, "_pccond"}, 32'(o_pcc), 32'(e.pcc));
        check({e.name, "_exc"}, 32'(o_exc), 32'(e.exc));
        if (e.exc != 0) check({e.name, "_cause"}, 32'(o_cause), 32'b01);
    endtask

    initial begin
        int  cyc;
        int  bad;
        bit  hit;
        logic [1:0] t_cause, t_src;
        logic       t_pcw, t_done, t_quiet;

        //             name     op         fw dw cyc      rw dst m2r chk size   mw pcc exc
        vecs.push_back(mk("add",   6'b000000, 0, 0, 4,       1, 1, 0, 0, 2'b00, 0, 0, 0));
        vecs.push_back(mk("addi",  6'b001000, 0, 0, 4,       1, 0, 0, 0, 2'b00, 0, 0, 0));
        vecs.push_back(mk("j",     6'b000010, 0, 0, 3,       0, 0, 0, 0, 2'b00, 0, 0, 0));
        vecs.push_back(mk("beq",   6'b000100, 0, 0, 3,       0, 0, 0, 0, 2'b00, 0, 3, 0));
        vecs.push_back(mk("lw",    6'b100011, 0, 0, 5,       1, 0, 1, 1, 2'b00, 0, 0, 0));
        vecs.push_back(mk("lh",    6'b100001, 0, 3, 8,       1, 0, 1, 1, 2'b11, 0, 0, 0));
        vecs.push_back(mk("lb",    6'b100000, 0, 1, 6,       1, 0, 1, 1, 2'b01, 0, 0, 0));
        vecs.push_back(mk("sb",    6'b101000, 0, 0, 4,       0, 0, 0, 1, 2'b01, 1, 0, 0));
        vecs.push_back(mk("beq2",  6'b000100, 0, 0, 3,       0, 0, 0, 0, 2'b00, 0, 3, 0));
        vecs.push_back(mk("sh",    6'b101001, 0, 2, 6,       0, 0, 0, 1, 2'b11, 3, 0, 0));
        vecs.push_back(mk("sw",    6'b101011, 0, 0, 4,       0, 0, 0, 1, 2'b00, 1, 0, 0));
        vecs.push_back(mk("addw3", 6'b000000, 3, 0, 7,       1, 1, 0, 0, 2'b00, 0, 0, 0));
        vecs.push_back(mk("ill3f", 6'b111111, 0, 0, ILL_CYC, 0, 0, 0, 0, 2'b00, 0, 0, ILL_EXC));
        vecs.push_back(mk("ill22", 6'b100010, 0, 0, ILL_CYC, 0, 0, 0, 0, 2'b00, 0, 0, ILL_EXC));
        vecs.push_back(mk("lww",   6'b100011, 2, 2, 9,       1, 0, 1, 1, 2'b00, 0, 0, 0));
        vecs.push_back(mk("ill01", 6'b000001, 0, 0, ILL_CYC, 0, 0, 0, 0, 2'b00, 0, 0, ILL_EXC));
        vecs.push_back(mk("addi1", 6'b001000, 1, 0, 5,       1, 0, 0, 0, 2'b00, 0, 0, 0));

        rst_n     = 1'b0;
        opcode    = 6'b000000;
        mem_ready = 1'b0;
        #2;
        check("rst_fetch", 32'({mem_read, iord, alu_src_b, mem_size}), 32'b100100);
        check("rst_quiet", 32'({reg_write, mem_write, instr_done, exc_valid, ir_write, pc_write}), 32'd0);
        check("rst_cause", 32'(exc_cause), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) run_instr(vecs[i]);

        // R-type must use the funct field in REX (cycle 3)
        run_instr(vecs[0]);
        check("add_rex_aluop", 32'(last_aluop3), 32'b10);

        // Asynchronous reset in the middle of MEMRD
        opcode    = 6'b100011;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        check("mid_memrd_iord", 32'({iord, mem_read}), 32'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_fetch", 32'({mem_read, iord, reg_write, mem_write}), 32'b1000);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'b000010;
        #1;
        check("post_rst_fetch", 32'({mem_read, iord, ir_write, reg_write}), 32'b1010);
        @(posedge clk); #1;
        mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("post_rst_decode", 32'({reg_write, alu_src_b}), 32'b011);
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst_jump", 32'({pc_write, pc_source, instr_done, reg_write}), 32'b11010);
        @(posedge clk); #1;

        // mem_ready held low in FETCH
        mem_ready = 1'b0;
        opcode    = 6'b000000;
`ifdef CTRL_EXC_EN
        cyc = 0;
        hit = 0;
        t_cause = 2'b00; t_src = 2'b00; t_pcw = 0; t_done = 0; t_quiet = 0;
        while (!hit && cyc < 20) begin
            cyc++;
            @(negedge clk);
            if (exc_valid) begin
                hit     = 1;
                t_cause = exc_cause;
                t_src   = pc_source;
                t_pcw   = pc_write;
                t_done  = instr_done;
                t_quiet = !(reg_write || mem_write || mem_read);
            end
            @(posedge clk); #1;
        end
        $display("instr fetch-timeout exc_at=%0d cause=%b", cyc, t_cause);
        check("tmo_cycle", 32'(cyc), 32'd5);
        check("tmo_cause", 32'(t_cause), 32'b10);
        check("tmo_exc_out", 32'({t_src, t_pcw, t_done, t_quiet}), 32'b11111);
        run_instr(vecs[1]);
        check("tmo_cause_held", 32'(exc_cause), 32'b10);
`else
        bad = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (!(mem_read && !iord && !exc_valid && !ir_write && !instr_done)) bad++;
            @(posedge clk); #1;
        end
        $display("instr fetch-stall 12 cycles bad_cycles=%0d", bad);
        check("stall_fetch_held", 32'(bad), 32'd0);
        run_instr(vecs[1]);
        check("no_exc_cause", 32'(exc_cause), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
